periph_bus_arbiter: RTL and testbench

//   Shares the single peripheral bus (sys_w_addr/sys_r_addr/sys_w_line/sys_r_line/sys_w/sys_r) between
//   NUM_MASTERS requesters, e.g. CPU load/store unit and DMA. Each transfer is one peripheral read or write.

---
 rtl/periph_bus_arbiter_pkg.sv | 14 +
 rtl/periph_bus_arbiter_rr_arbiter.sv | 39 +++
 rtl/periph_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_periph_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: bus widths and FSM state encoding.
package periph_bus_arbiter_pkg;

  localparam int unsigned PbusAw = 32;
  localparam int unsigned PbusDw = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StRdWait = 2'd2,
    StAck    = 2'd3
  } pbus_state_e;

endpackage

// File: rtl/periph_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned     sum;
  logic [PtrW-1:0] cand;
  logic            found;

  // Walk ptr, ptr+1, ... and grant the first requester found.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(ptr_i) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      cand = PtrW'(sum);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the single peripheral bus between NUM_MASTERS requesters.
// One transfer at a time: IDLE -> ISSUE -> (RDWAIT) -> ACK. All outputs are registered.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [PbusAw*NUM_MASTERS-1:0] m_addr_i,
  input  logic [PbusDw*NUM_MASTERS-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [PbusDw-1:0]             m_rdata_o,
  output logic [PbusAw-1:0]             sys_w_addr_o,
  output logic [PbusAw-1:0]             sys_r_addr_o,
  output logic [PbusDw-1:0]             sys_w_line_o,
  input  logic [PbusDw-1:0]             sys_r_line_i,
  output logic                          sys_w_o,
  output logic                          sys_r_o
);

  localparam int unsigned PtrW = $clog2(NUM_MASTERS);

  pbus_state_e              state_q;
  logic [PtrW-1:0]          ptr_q;
  logic [PtrW-1:0]          gnt_q;
  logic                     we_q;
  logic [PbusAw-1:0]        addr_q;
  logic [PbusDw-1:0]        wdata_q;
  logic [NUM_MASTERS-1:0]   m_ack_q;
  logic [PbusDw-1:0]        m_rdata_q;
  logic [PbusAw-1:0]        sys_w_addr_q;
  logic [PbusAw-1:0]        sys_r_addr_q;
  logic [PbusDw-1:0]        sys_w_line_q;
  logic                     sys_w_q;
  logic                     sys_r_q;

  logic [NUM_MASTERS-1:0]   arb_gnt;
  logic [PtrW-1:0]          arb_idx;
  logic                     arb_valid;

  rr_arbiter #(
    .N    (NUM_MASTERS),
    .PtrW (PtrW)
  ) u_rr (
    .req_i   (m_req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Transfer sequencer; strobes and ack default low so each is a single-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      gnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m_ack_q      <= '0;
      m_rdata_q    <= '0;
      sys_w_addr_q <= '0;
      sys_r_addr_q <= '0;
      sys_w_line_q <= '0;
      sys_w_q      <= 1'b0;
      sys_r_q      <= 1'b0;
    end else begin
      m_ack_q <= '0;
      sys_w_q <= 1'b0;
      sys_r_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            gnt_q   <= arb_idx;
            we_q    <= m_we_i[arb_idx];
            addr_q  <= m_addr_i[arb_idx*PbusAw +: PbusAw];
            wdata_q <= m_wdata_i[arb_idx*PbusDw +: PbusDw];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          sys_w_addr_q <= addr_q;
          sys_r_addr_q <= addr_q;
          if (we_q) begin
            sys_w_q      <= 1'b1;
            sys_w_line_q <= wdata_q;
            state_q      <= StAck;
          end else begin
            sys_r_q <= 1'b1;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          // Peripheral samples the strobe on this edge and drives read data next cycle.
          state_q <= StAck;
        end
        StAck: begin
          // Read data becomes valid on the bus in this cycle; capture it with the ack.
          if (!we_q) begin
            m_rdata_q <= sys_r_line_i;
          end
          m_ack_q[gnt_q] <= 1'b1;
          ptr_q          <= (gnt_q == PtrW'(NUM_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_ack_o      = m_ack_q;
  assign m_rdata_o    = m_rdata_q;
  assign sys_w_addr_o = sys_w_addr_q;
  assign sys_r_addr_o = sys_r_addr_q;
  assign sys_w_line_o = sys_w_line_q;
  assign sys_w_o      = sys_w_q;
  assign sys_r_o      = sys_r_q;

  logic unused_gnt;
  assign unused_gnt = ^arb_gnt;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench: a 2-master instance for the basic, contention, reset and drop cases,
// and a 4-master instance for the fairness case.
module tb_periph_bus_arbiter;

  logic clk;
  logic rst;

  // 2-master instance
  logic [1:0]  a_req, a_we, a_ack;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_waddr, a_raddr, a_wline, a_rline;
  logic        a_sw, a_sr;
  logic [31:0] a_rd_val;

  // 4-master instance
  logic [3:0]   b_req, b_we, b_ack;
  logic [127:0] b_addr, b_wdata;
  logic [31:0]  b_rdata, b_waddr, b_raddr, b_wline;
  logic         b_sw, b_sr;

  int total;
  int bad;

  periph_bus_arbiter #(.NUM_MASTERS(2)) u_dut2 (
    .clk_i        (clk),
    .rst_i        (rst),
    .m_req_i      (a_req),
    .m_we_i       (a_we),
    .m_addr_i     (a_addr),
    .m_wdata_i    (a_wdata),
    .m_ack_o      (a_ack),
    .m_rdata_o    (a_rdata),
    .sys_w_addr_o (a_waddr),
    .sys_r_addr_o (a_raddr),
    .sys_w_line_o (a_wline),
    .sys_r_line_i (a_rline),
    .sys_w_o      (a_sw),
    .sys_r_o      (a_sr)
  );

  periph_bus_arbiter #(.NUM_MASTERS(4)) u_dut4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .m_req_i      (b_req),
    .m_we_i       (b_we),
    .m_addr_i     (b_addr),
    .m_wdata_i    (b_wdata),
    .m_ack_o      (b_ack),
    .m_rdata_o    (b_rdata),
    .sys_w_addr_o (b_waddr),
    .sys_r_addr_o (b_raddr),
    .sys_w_line_o (b_wline),
    .sys_r_line_i (32'h0),
    .sys_w_o      (b_sw),
    .sys_r_o      (b_sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: sees the read strobe on an edge, drives data during the next cycle.
  always @(posedge clk) begin
    if (a_sr) a_rline <= a_rd_val;
    else      a_rline <= 32'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] ack_log [1:14];
  int         n_ack, n_w, n_r, ack3_cyc, others;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_rd_val = '0; a_rline = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    step(); step();

    // Reset values
    chk("rst_ack",    32'(a_ack), 32'h0);
    chk("rst_rdata",  a_rdata,    32'h0);
    chk("rst_sys_w",  32'(a_sw),  32'h0);
    chk("rst_sys_r",  32'(a_sr),  32'h0);
    chk("rst_waddr",  a_waddr,    32'h0);
    chk("rst_raddr",  a_raddr,    32'h0);
    chk("rst_wline",  a_wline,    32'h0);
    chk("rst_ack4",   32'(b_ack), 32'h0);
    rst = 1'b0;
    step();

    // 1. Single write from master 0
    a_req = 2'b01; a_we = 2'b01; a_addr[31:0] = 32'h100; a_wdata[31:0] = 32'hA5A5_0001;
    step();
    chk("w_c1_sys_w", 32'(a_sw), 32'h0);
    step();
    chk("w_c2_sys_w", 32'(a_sw), 32'h1);
    chk("w_c2_waddr", a_waddr,   32'h100);
    chk("w_c2_wline", a_wline,   32'hA5A5_0001);
    chk("w_c2_sys_r", 32'(a_sr), 32'h0);
    chk("w_c2_ack",   32'(a_ack), 32'h0);
    step();
    chk("w_c3_ack",   32'(a_ack), 32'h1);
    chk("w_c3_sys_w", 32'(a_sw),  32'h0);
    a_req = 2'b00;
    step();
    chk("w_c4_ack",   32'(a_ack), 32'h0);

    // 2. Single read from master 1
    a_req = 2'b10; a_we = 2'b00; a_addr[63:32] = 32'h101; a_rd_val = 32'hDEAD_BEEF;
    step();
    step();
    chk("r_c2_sys_r", 32'(a_sr), 32'h1);
    chk("r_c2_raddr", a_raddr,   32'h101);
    chk("r_c2_sys_w", 32'(a_sw), 32'h0);
    step();
    chk("r_c3_sys_r", 32'(a_sr),  32'h0);
    chk("r_c3_ack",   32'(a_ack), 32'h0);
    step();
    chk("r_c4_ack",   32'(a_ack), 32'h2);
    chk("r_c4_rdata", a_rdata,    32'hDEAD_BEEF);
    a_req = 2'b00;
    step();
    chk("r_c5_ack",   32'(a_ack), 32'h0);
    chk("r_c5_rdata", a_rdata,    32'hDEAD_BEEF);

    // 3. Contention from reset: master 0 writes, master 1 reads
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_req = 2'b11; a_we = 2'b01;
    a_addr = {32'h204, 32'h200}; a_wdata = {32'h0, 32'h5555_AAAA}; a_rd_val = 32'h1234_5678;
    n_ack = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      chk("cont_excl", 32'(a_sw & a_sr), 32'h0);
      ack_log[c] = a_ack;
      if (a_ack != 2'b00) n_ack++;
      if (c == 7) chk("cont_rdata", a_rdata, 32'h1234_5678);
    end
    a_req = 2'b00;
    chk("cont_ack3",  32'(ack_log[3]),  32'h1);
    chk("cont_ack7",  32'(ack_log[7]),  32'h2);
    chk("cont_ack10", 32'(ack_log[10]), 32'h1);
    chk("cont_ack14", 32'(ack_log[14]), 32'h2);
    chk("cont_nack",  32'(n_ack),       32'd4);

    // 4. Fairness on 4 masters: 0..2 write continuously, master 3 joins after cycle 4
    rst = 1'b1;
    step();
    rst = 1'b0;
    b_req = 4'b0111; b_we = 4'b1111;
    ack3_cyc = 0; others = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 4) b_req[3] = 1'b1;
      if (b_ack[3]) begin
        ack3_cyc = c;
        b_req[3] = 1'b0;
        break;
      end
      if (c > 4 && b_ack != 4'b0000) others++;
    end
    b_req = '0;
    chk("fair_ack3_cycle", 32'(ack3_cyc), 32'd12);
    chk("fair_others",     32'(others),   32'd2);

    // 5. Reset asserted while in RDWAIT, then the same read completes normally
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_req = 2'b10; a_we = 2'b00; a_addr[63:32] = 32'h101; a_rd_val = 32'h0BAD_F00D;
    step();
    step();
    chk("rr_c2_sys_r", 32'(a_sr), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_rst_ack",   32'(a_ack), 32'h0);
    chk("rr_rst_sys_r", 32'(a_sr),  32'h0);
    chk("rr_rst_raddr", a_raddr,    32'h0);
    chk("rr_rst_rdata", a_rdata,    32'h0);
    step(); step();
    chk("rr2_c2_raddr", a_raddr,    32'h101);
    step();
    chk("rr2_c3_ack",   32'(a_ack), 32'h0);
    step();
    chk("rr2_c4_ack",   32'(a_ack), 32'h2);
    chk("rr2_c4_rdata", a_rdata,    32'h0BAD_F00D);
    a_req = 2'b00;

    // 6. Request dropped after ISSUE: transfer still completes exactly once
    step();
    a_req = 2'b01; a_we = 2'b01; a_addr[31:0] = 32'h300; a_wdata[31:0] = 32'h1111_2222;
    n_ack = 0; n_w = 0; n_r = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 2) a_req = 2'b00;
      if (a_ack != 2'b00) n_ack++;
      if (a_sw) n_w++;
      if (a_sr) n_r++;
      if (c == 3) chk("drop_c3_ack", 32'(a_ack), 32'h1);
    end
    chk("drop_nack",  32'(n_ack), 32'd1);
    chk("drop_nw",    32'(n_w),   32'd1);
    chk("drop_nr",    32'(n_r),   32'd0);
    chk("drop_waddr", a_waddr,    32'h300);
    chk("drop_wline", a_wline,    32'h1111_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
